// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store controller: funct3 codes,
// FSM states and access legality checks.
package lsu_pkg;

    localparam int XLEN = 32;

    // Load and store codes share encodings (SB=LB, SH=LH, SW=LW).
    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD_RESP,
        S_STORE,
        S_MERGE_STORE,
        S_ERROR
    } lsu_state_e;

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: return off[0];
            F3_W:        return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    // Stores have no unsigned variants, so BU/HU codes are illegal with we=1.
    function automatic logic is_illegal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return !(f3 inside {F3_B, F3_H, F3_W});
        return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: load lane select with sign/zero extension, and sub-word
// store merge into the word read back from memory.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] mem_rd,
    input  logic [XLEN-1:0] wdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] store_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_rd[7:0];
        case (offset)
            2'd1:    byte_sel = mem_rd[15:8];
            2'd2:    byte_sel = mem_rd[23:16];
            2'd3:    byte_sel = mem_rd[31:24];
            default: byte_sel = mem_rd[7:0];
        endcase
        half_sel = offset[1] ? mem_rd[31:16] : mem_rd[15:0];

        load_data = mem_rd;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'b0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'b0, half_sel};
            default: load_data = mem_rd;
        endcase
    end

    always_comb begin
        store_data = mem_rd;
        case (funct3[1:0])
            2'b00: begin
                case (offset)
                    2'd0: store_data[7:0]   = wdata[7:0];
                    2'd1: store_data[15:8]  = wdata[7:0];
                    2'd2: store_data[23:16] = wdata[7:0];
                    2'd3: store_data[31:24] = wdata[7:0];
                    default: store_data = mem_rd;
                endcase
            end
            2'b01: begin
                if (offset[1])
                    store_data[31:16] = wdata[15:0];
                else
                    store_data[15:0] = wdata[15:0];
            end
            default: store_data = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: turns byte/half/word accesses into word accesses on a
// synchronous-read memory, one outstanding request at a time.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req,
    input  logic                     we,
    input  logic [2:0]               funct3,
    input  logic [31:0]              addr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic                     ready,
    output logic                     done,
    output logic                     err,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic [ADDRESS_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    output logic                     mem_we,
    input  logic [DATA_WIDTH-1:0]    mem_rd,
    output lsu_state_e               fsm_state
);

    // Handshake: a request is taken on any rising edge where req && ready;
    // the core holds req until then, and done pulses once per taken request.

    lsu_state_e state_q, state_d;
    logic                     we_q;
    logic [2:0]               f3_q;
    logic [ADDRESS_WIDTH+1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [DATA_WIDTH-1:0]    load_data, store_data;
    logic                     done_raw, err_raw, we_raw;
    logic                     unused_addr_bits;

    assign unused_addr_bits = ^addr[31:ADDRESS_WIDTH+2];

    lsu_align u_align (
        .mem_rd     (mem_rd),
        .wdata      (wdata_q),
        .offset     (addr_q[1:0]),
        .funct3     (f3_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rdata   <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && req) begin
                we_q    <= we;
                f3_q    <= funct3;
                addr_q  <= addr[ADDRESS_WIDTH+1:0];
                wdata_q <= wdata;
            end
            if (state_q == S_LOAD_RESP)
                rdata <= load_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        done_raw = 1'b0;
        err_raw  = 1'b0;
        we_raw   = 1'b0;
        mem_wd   = wdata_q;
        mem_a    = addr_q[ADDRESS_WIDTH+1:2];
        case (state_q)
            S_IDLE: begin
                mem_a = addr[ADDRESS_WIDTH+1:2];
                if (req) begin
                    if (is_illegal(we, funct3) || is_misaligned(funct3, addr[1:0]))
                        state_d = S_ERROR;
                    else if (we && funct3 == F3_W)
                        state_d = S_STORE;
                    else
                        state_d = S_READ;
                end
            end
            S_READ:      state_d = we_q ? S_MERGE_STORE : S_LOAD_RESP;
            S_LOAD_RESP: begin
                done_raw = 1'b1;
                state_d  = S_IDLE;
            end
            S_STORE: begin
                we_raw   = 1'b1;
                done_raw = 1'b1;
                state_d  = S_IDLE;
            end
            S_MERGE_STORE: begin
                mem_wd   = store_data;
                we_raw   = 1'b1;
                done_raw = 1'b1;
                state_d  = S_IDLE;
            end
            S_ERROR: begin
                done_raw = 1'b1;
                err_raw  = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A reset cycle aborts the access outright: no write and no completion.
    assign mem_we    = we_raw & rst_n;
    assign done      = done_raw & rst_n;
    assign err       = err_raw & rst_n;
    assign ready     = rst_n && (state_q == S_IDLE);
    assign fsm_state = state_q;

endmodule
